rr_priority_arbiter: RTL and testbench

//  Parametrised round-robin arbiter with a registered, held grant and a grant/ack handshake.

---
 rtl/rr_priority_arbiter_pkg.sv | 19 +
 rtl/rr_priority_arbiter_if.sv | 38 +++
 rtl/rr_priority_arbiter_lsb_pick.sv | 11 +
 rtl/rr_priority_arbiter.sv | 104 ++++++++++
 tb/tb_rr_priority_arbiter.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Encodes a one-hot (or zero) vector of up to 32 bits; returns 0 for zero.
  function automatic int unsigned onehot2bin(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle for rr_priority_arbiter; lock exists only with RR_ARB_LOCK_EN.
interface rr_arb_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned IDW = $clog2(N);

  logic [N-1:0]   req;
  logic           ack;
`ifdef RR_ARB_LOCK_EN
  logic           lock;
`endif
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           gnt_valid;

  modport master (
    output req,
    output ack,
`ifdef RR_ARB_LOCK_EN
    output lock,
`endif
    input  grant,
    input  grant_id,
    input  gnt_valid
  );

  modport slave (
    input  req,
    input  ack,
`ifdef RR_ARB_LOCK_EN
    input  lock,
`endif
    output grant,
    output grant_id,
    output gnt_valid
  );

endinterface

// File: rtl/rr_priority_arbiter_lsb_pick.sv
// Isolates the lowest set bit of a vector: x & ~(x-1), N-bit wraparound.
module lsb_pick #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] x_i,
  output logic [N-1:0] lsb_o
);

  assign lsb_o = x_i & ~(x_i - N'(1));

endmodule

// File: rtl/rr_priority_arbiter.sv
// Round-robin arbiter with registered, held grant and grant/ack handshake.
// Optional RR_ARB_LOCK_EN: lock input keeps the grant across ack.
module rr_priority_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input logic   clk,
  input logic   rst,
  rr_arb_if.slave bus
);

  localparam int unsigned IDW = $clog2(N);

  state_e         state_q, state_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic           gnt_valid_q, gnt_valid_d;

  logic [N-1:0]   above_mask;
  logic [N-1:0]   req_eff;
  logic [N-1:0]   mask_eff;
  logic [N-1:0]   pick_m, pick_u, pick;
  logic           ack_rel;
  logic           release_now;

  // In BUSY the candidate set excludes the holder and is ranked against the
  // post-release mask, so the successor is chosen in the same cycle.
  assign above_mask = ~((grant_q << 1) - N'(1));
  assign req_eff    = bus.req & ~grant_q;
  assign mask_eff   = (state_q == BUSY) ? above_mask : mask_q;

  lsb_pick #(.N(N)) u_pick_masked (
    .x_i   (req_eff & mask_eff),
    .lsb_o (pick_m)
  );

  lsb_pick #(.N(N)) u_pick_unmasked (
    .x_i   (req_eff),
    .lsb_o (pick_u)
  );

  assign pick = (|(req_eff & mask_eff)) ? pick_m : pick_u;

`ifdef RR_ARB_LOCK_EN
  assign ack_rel = bus.ack & ~bus.lock;
`else
  assign ack_rel = bus.ack;
`endif

  assign release_now = ack_rel | ~(|(bus.req & grant_q));

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    grant_d     = grant_q;
    gnt_valid_d = gnt_valid_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d     = pick;
          gnt_valid_d = 1'b1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          mask_d = above_mask;
          if (|req_eff) begin
            grant_d = pick;
          end else begin
            grant_d     = '0;
            gnt_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    grant_id_d = IDW'(onehot2bin(32'(grant_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '1;
      grant_q     <= '0;
      grant_id_q  <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      grant_q     <= grant_d;
      grant_id_q  <= grant_id_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed plus random bench for rr_priority_arbiter (N=4) against a circular-scan model.
module tb_rr_priority_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lock_m = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state: whether a grant is held, the holder index, and where the
  // next circular scan begins.
  bit m_busy  = 1'b0;
  int m_g     = 0;
  int m_start = 0;

  always #5 clk = ~clk;

  rr_arb_if #(.N(N)) bus ();

  rr_priority_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef RR_ARB_LOCK_EN
  assign bus.lock = lock_m;
`endif

  function automatic int scan(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_update(input logic r, input logic [N-1:0] rq, input logic a, input logic lk);
    logic [N-1:0] rest;
    if (r) begin
      m_busy = 1'b0; m_g = 0; m_start = 0;
    end else if (!m_busy) begin
      if (rq != '0) begin
        m_g = scan(rq, m_start);
        m_busy = 1'b1;
      end
    end else if ((a && !lk) || !rq[m_g]) begin
      m_start = (m_g + 1) % N;
      rest = rq;
      rest[m_g] = 1'b0;
      if (rest != '0) m_g = scan(rest, m_start);
      else begin
        m_busy = 1'b0; m_g = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    logic [N-1:0] eg;
    eg = m_busy ? (N'(1) << m_g) : '0;
    chk({tag, ".grant"}, 32'(bus.grant), 32'(eg));
    chk({tag, ".grant_id"}, 32'(bus.grant_id), m_busy ? 32'(m_g) : 32'd0);
    chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(m_busy));
  endtask

  task automatic step(input string tag, input logic r, input logic [N-1:0] rq,
                      input logic a, input logic lk);
    rst     = r;
    bus.req = rq;
    bus.ack = a;
    lock_m  = lk;
    @(posedge clk);
    model_update(r, rq, a, lk);
    #1;
    chk_model(tag);
  endtask

  initial begin
    bus.req = '0;
    bus.ack = 1'b0;

    // 1: reset with all requesting, then first grant one cycle after release
    step("rst0", 1'b1, 4'b1111, 1'b0, 1'b0);
    step("rst1", 1'b1, 4'b1111, 1'b0, 1'b0);
    step("first", 1'b0, 4'b1111, 1'b0, 1'b0);
    chk("first_const", 32'(bus.grant), 32'h1);

    // 2: all requesting, ack every cycle -> rotation
    step("rot1", 1'b0, 4'b1111, 1'b1, 1'b0);
    chk("rot1_const", 32'(bus.grant), 32'h2);
    step("rot2", 1'b0, 4'b1111, 1'b1, 1'b0);
    chk("rot2_const", 32'(bus.grant), 32'h4);
    step("rot3", 1'b0, 4'b1111, 1'b1, 1'b0);
    chk("rot3_const", 32'(bus.grant), 32'h8);
    chk("rot3_id", 32'(bus.grant_id), 32'd3);
    step("rot4", 1'b0, 4'b1111, 1'b1, 1'b0);
    chk("rot4_const", 32'(bus.grant), 32'h1);

    // 3: hold 0010 for 5 cycles without ack
    step("to0010", 1'b0, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("hold", 1'b0, 4'b1111, 1'b0, 1'b0);
      chk("hold_const", 32'(bus.grant), 32'h2);
    end
    step("after_hold", 1'b0, 4'b1111, 1'b1, 1'b0);
    chk("after_hold_const", 32'(bus.grant), 32'h4);

    // 4: wrap from index 3, then drain to IDLE
    step("to1000", 1'b0, 4'b1111, 1'b1, 1'b0);
    step("wrap", 1'b0, 4'b1001, 1'b1, 1'b0);
    chk("wrap_const", 32'(bus.grant), 32'h1);
    step("drain", 1'b0, 4'b0000, 1'b1, 1'b0);
    chk("drain_valid", 32'(bus.gnt_valid), 32'd0);

    // 5: abort path
    step("grab2", 1'b0, 4'b0100, 1'b0, 1'b0);
    chk("grab2_const", 32'(bus.grant), 32'h4);
    step("abort", 1'b0, 4'b0001, 1'b0, 1'b0);
    chk("abort_const", 32'(bus.grant), 32'h1);
    chk("abort_mask", 32'(dut.mask_q), 32'h8);

    // single requester: released to IDLE, regranted one cycle later
    step("single_rel", 1'b0, 4'b0001, 1'b1, 1'b0);
    chk("single_rel_const", 32'(bus.grant), 32'h0);
    step("single_regrant", 1'b0, 4'b0001, 1'b0, 1'b0);
    chk("single_regrant_const", 32'(bus.grant), 32'h1);

    // reset mid-BUSY with ack and requests present
    step("rst_busy", 1'b1, 4'b1111, 1'b1, 1'b0);
    chk("rst_busy_const", 32'(bus.grant), 32'h0);

`ifdef RR_ARB_LOCK_EN
    // 6: lock holds across ack; reset overrides lock
    step("lk_first", 1'b0, 4'b1111, 1'b0, 1'b0);
    step("lk_to0010", 1'b0, 4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("lk_hold", 1'b0, 4'b1111, 1'b1, 1'b1);
      chk("lk_hold_const", 32'(bus.grant), 32'h2);
    end
    step("lk_rel", 1'b0, 4'b1111, 1'b1, 1'b0);
    chk("lk_rel_const", 32'(bus.grant), 32'h4);
    step("lk_rst", 1'b1, 4'b1111, 1'b1, 1'b1);
    chk("lk_rst_const", 32'(bus.grant), 32'h0);
`endif

    // random traffic against the model, with the one-hot invariant
    step("rnd_rst", 1'b1, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic r, a, lk;
      logic [N-1:0] rq;
      r  = ($urandom_range(0, 39) == 0);
      rq = N'($urandom_range(0, 15));
      a  = ($urandom_range(0, 2) != 0);
`ifdef RR_ARB_LOCK_EN
      lk = ($urandom_range(0, 3) == 0);
`else
      lk = 1'b0;
`endif
      step("rnd", r, rq, a, lk);
      chk("rnd_onehot", 32'($onehot0(bus.grant)), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
